// File: rtl/axi_llc_pkg.sv
// Shared descriptor layout and AXI burst encodings for the LLC AX splitter.
package axi_llc_pkg;
    localparam int unsigned LlcNumChan   = 2;
    localparam int unsigned LlcAddrWidth = 64;
    localparam int unsigned LlcIdWidth   = 6;
    localparam int unsigned LlcChanWidth = (LlcNumChan > 1) ? $clog2(LlcNumChan) : 1;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef struct packed {
        logic [LlcChanWidth-1:0] chan_idx;
        logic [LlcIdWidth-1:0]   id;
        logic [LlcAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    bypass;
        logic                    x_last;
    } desc_t;
endpackage

// File: rtl/axi_llc_desc_fifo.sv
// Fall-through descriptor FIFO: an empty FIFO presents its input directly on the output.
module axi_llc_desc_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] count;
    logic                push, pop, store, drain;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign empty_o     = (count == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign in_ready_o  = (count != CntWidth'(Depth)) | out_ready_i;
    assign out_valid_o = !empty_o | in_valid_i;
    assign out_data_o  = empty_o ? in_data_i : mem[rd_ptr];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign store       = push & !(empty_o & pop);
    assign drain       = pop & !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= ptr_inc(wr_ptr);
            if (drain) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CntWidth'(store) - CntWidth'(drain);
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem[wr_ptr] <= in_data_i;
    end
endmodule

// File: rtl/axi_llc_ax_splitter_mc.sv
// Round-robin arbiter over NumChan AX streams; cuts each accepted burst into per-line descriptors.
module axi_llc_ax_splitter_mc
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumChan   = LlcNumChan,
    parameter int unsigned AddrWidth = LlcAddrWidth,
    parameter int unsigned IdWidth   = LlcIdWidth,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned BlockSize = 8,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic [NumChan-1:0]           ax_valid_i,
    output logic [NumChan-1:0]           ax_ready_o,
    input  logic [NumChan*AddrWidth-1:0] ax_addr_i,
    input  logic [NumChan*8-1:0]         ax_len_i,
    input  logic [NumChan*3-1:0]         ax_size_i,
    input  logic [NumChan*2-1:0]         ax_burst_i,
    input  logic [NumChan*IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0]         cached_start_i,
    input  logic [AddrWidth-1:0]         cached_end_i,
    output desc_t                        desc_o,
    output logic                         desc_valid_o,
    input  logic                         desc_ready_i,
    output logic                         busy_o
);
    localparam int unsigned ChanWidth = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned LineBytes = BlockSize * (DataWidth / 8);
    localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineBytes - 1);

    typedef enum logic {IDLE, CUT} state_e;
    state_e state_q, state_d;

    logic [ChanWidth-1:0] rr_ptr_q, grant_idx, idx_hi, idx_lo;
    logic                 any_hi, any_lo, accept;
    logic [AddrWidth-1:0] in_addr;
    logic [1:0]           in_burst;

    logic [AddrWidth-1:0] addr_q;
    logic [8:0]           len_rem_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [IdWidth-1:0]   id_q;
    logic [ChanWidth-1:0] chan_q;
    logic                 bypass_q;

    logic [AddrWidth-1:0] off, room_full;
    logic [8:0]           len_p1, beats;
    logic                 x_last, push_ready, push_fire, fifo_empty;
    desc_t                desc_d;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        any_hi = 1'b0;
        any_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int j = NumChan - 1; j >= 0; j--) begin
            if (ax_valid_i[j]) begin
                any_lo = 1'b1;
                idx_lo = ChanWidth'(j);
                if (ChanWidth'(j) >= rr_ptr_q) begin
                    any_hi = 1'b1;
                    idx_hi = ChanWidth'(j);
                end
            end
        end
    end

    assign grant_idx  = any_hi ? idx_hi : idx_lo;
    assign accept     = (state_q == IDLE) & !stall_i & any_lo & !rst_i;
    assign ax_ready_o = accept ? (NumChan'(1) << grant_idx) : '0;
    assign in_addr    = ax_addr_i[grant_idx*AddrWidth +: AddrWidth];
    assign in_burst   = ax_burst_i[grant_idx*2 +: 2];

    always_comb begin
        off       = addr_q & LineMask;
        room_full = (AddrWidth'(LineBytes) - off) >> size_q;
        len_p1    = len_rem_q + 9'd1;
        if (bypass_q || room_full >= AddrWidth'(len_p1)) begin
            beats = len_p1;
        end else if (room_full == '0) begin
            // A beat wider than the rest of the line still goes out alone so the cutter advances.
            beats = 9'd1;
        end else begin
            beats = room_full[8:0];
        end
        x_last = (beats == len_p1);
        desc_d = '{chan_idx: chan_q, id: id_q, addr: addr_q, len: 8'(beats - 9'd1),
                   size: size_q, burst: burst_q, bypass: bypass_q, x_last: x_last};
    end

    assign push_fire = (state_q == CUT) & push_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CUT;
            CUT:     if (push_fire && x_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_ptr_q <= (grant_idx == ChanWidth'(NumChan - 1)) ? '0 : grant_idx + ChanWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q    <= in_addr;
            len_rem_q <= {1'b0, ax_len_i[grant_idx*8 +: 8]};
            size_q    <= ax_size_i[grant_idx*3 +: 3];
            burst_q   <= in_burst;
            id_q      <= ax_id_i[grant_idx*IdWidth +: IdWidth];
            chan_q    <= grant_idx;
            bypass_q  <= (in_burst != BURST_INCR) || (in_addr < cached_start_i) ||
                         (in_addr >= cached_end_i);
        end else if (push_fire && !x_last) begin
            addr_q    <= (addr_q & ~LineMask) + AddrWidth'(LineBytes);
            len_rem_q <= len_rem_q - beats;
        end
    end

    axi_llc_desc_fifo #(
        .Width ($bits(desc_t)),
        .Depth (FifoDepth)
    ) u_desc_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (state_q == CUT),
        .in_ready_o  (push_ready),
        .in_data_i   (desc_d),
        .out_valid_o (desc_valid_o),
        .out_ready_i (desc_ready_i),
        .out_data_o  (desc_o),
        .empty_o     (fifo_empty)
    );

    assign busy_o = (state_q == CUT) | !fifo_empty;
endmodule

// File: tb/tb_axi_llc_ax_splitter_mc.sv
// Randomised bench for the multi-channel AX splitter with a queue-based line-cutting reference.
module tb_axi_llc_ax_splitter_mc;
    import axi_llc_pkg::*;

    localparam int NC = 2;
    localparam int AW = 64;
    localparam int IW = 6;
    localparam longint unsigned LB = 64;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [IW-1:0] id;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic desc_ready = 1'b1;
    logic [NC-1:0]    ax_valid, ax_ready;
    logic [NC*AW-1:0] ax_addr;
    logic [NC*8-1:0]  ax_len;
    logic [NC*3-1:0]  ax_size;
    logic [NC*2-1:0]  ax_burst;
    logic [NC*IW-1:0] ax_id;
    logic [AW-1:0]    cstart = '0;
    logic [AW-1:0]    cend = 64'h10_0000;
    desc_t            desc;
    logic             desc_valid, busy;

    logic [AW-1:0] ch_addr [NC];
    logic [7:0]    ch_len [NC];
    logic [2:0]    ch_size [NC];
    logic [1:0]    ch_burst [NC];
    logic [IW-1:0] ch_id [NC];
    logic          ch_valid [NC] = '{default: 1'b0};

    burst_t bq [NC][256];
    int     head [NC] = '{default: 0};
    int     tail [NC] = '{default: 0};

    desc_t       exp_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int          model_rr = 0, m_pick, m_c, m_g;
    logic [NC-1:0] hs_mask = '0, m_exp_rdy;
    int          grant_log [16];
    int          gl_n = 0;
    int          desc_cnt = 0;
    logic        hold_prev = 1'b0;
    desc_t       held;
    burst_t      m_b;

    always #5 clk = ~clk;

    always_comb begin
        ax_addr = '0; ax_len = '0; ax_size = '0; ax_burst = '0; ax_id = '0; ax_valid = '0;
        for (int i = 0; i < NC; i++) begin
            ax_addr[i*AW +: AW] = ch_addr[i];
            ax_len[i*8 +: 8]    = ch_len[i];
            ax_size[i*3 +: 3]   = ch_size[i];
            ax_burst[i*2 +: 2]  = ch_burst[i];
            ax_id[i*IW +: IW]   = ch_id[i];
            ax_valid[i]         = ch_valid[i];
        end
    end

    axi_llc_ax_splitter_mc dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .ax_valid_i     (ax_valid),
        .ax_ready_o     (ax_ready),
        .ax_addr_i      (ax_addr),
        .ax_len_i       (ax_len),
        .ax_size_i      (ax_size),
        .ax_burst_i     (ax_burst),
        .ax_id_i        (ax_id),
        .cached_start_i (cstart),
        .cached_end_i   (cend),
        .desc_o         (desc),
        .desc_valid_o   (desc_valid),
        .desc_ready_i   (desc_ready),
        .busy_o         (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the burst line by line, beats per line = bytes left in line / bytes per beat.
    function automatic void model_burst(input int ch, input burst_t b);
        desc_t           d;
        longint unsigned a, line_end;
        int              remaining, n;
        d.chan_idx = LlcChanWidth'(ch);
        d.id       = b.id;
        d.size     = b.size;
        d.burst    = b.burst;
        if (b.burst != 2'(BURST_INCR) || b.addr < cstart || b.addr >= cend) begin
            d.addr = b.addr; d.len = b.len; d.bypass = 1'b1; d.x_last = 1'b1;
            exp_q.push_back(d);
            return;
        end
        d.bypass  = 1'b0;
        a         = b.addr;
        remaining = int'(b.len) + 1;
        while (remaining > 0) begin
            line_end = (a / LB + 1) * LB;
            n = int'((line_end - a) / (64'd1 << b.size));
            if (n > remaining) n = remaining;
            d.addr   = a;
            d.len    = 8'(n - 1);
            d.x_last = (n == remaining);
            exp_q.push_back(d);
            remaining -= n;
            a = line_end;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_rr  = 0;
            hs_mask   = '0;
            gl_n      = 0;
            hold_prev = 1'b0;
        end else begin
            hs_mask = ax_valid & ax_ready;
            if (stall) check_eq("stall_ready", ax_ready, '0);
            if (ax_ready != '0) begin
                m_pick = -1;
                for (int k = 0; k < NC; k++) begin
                    m_c = (model_rr + k) % NC;
                    if (m_pick < 0 && ax_valid[m_c]) m_pick = m_c;
                end
                m_exp_rdy = (m_pick < 0) ? '0 : NC'(1) << m_pick;
                check_eq("grant", ax_ready, m_exp_rdy);
            end
            m_g = -1;
            for (int k = 0; k < NC; k++) if (hs_mask[k] && m_g < 0) m_g = k;
            if (m_g >= 0) begin
                m_b = '{addr: ch_addr[m_g], len: ch_len[m_g], size: ch_size[m_g],
                        burst: ch_burst[m_g], id: ch_id[m_g]};
                model_burst(m_g, m_b);
                model_rr = (m_g + 1) % NC;
                if (gl_n < 16) grant_log[gl_n] = m_g;
                gl_n++;
            end
            if (hold_prev) begin
                check_eq("hold_valid", desc_valid, 1);
                check_eq("hold_data", desc, held);
            end
            if (desc_valid && desc_ready) begin
                if (exp_q.size() == 0) check_eq("desc_extra", 0, 1);
                else check_eq("desc", desc, exp_q.pop_front());
                desc_cnt++;
            end
            hold_prev = desc_valid && !desc_ready;
            held      = desc;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NC; c++) begin
            if (rst) begin
                ch_valid[c] = 1'b0;
                head[c]     = tail[c];
            end else begin
                if (hs_mask[c]) ch_valid[c] = 1'b0;
                if (!ch_valid[c] && head[c] != tail[c]) begin
                    ch_addr[c]  = bq[c][head[c] % 256].addr;
                    ch_len[c]   = bq[c][head[c] % 256].len;
                    ch_size[c]  = bq[c][head[c] % 256].size;
                    ch_burst[c] = bq[c][head[c] % 256].burst;
                    ch_id[c]    = bq[c][head[c] % 256].id;
                    ch_valid[c] = 1'b1;
                    head[c]++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input int ch, input logic [AW-1:0] a, input int len, input int size,
                           input logic [1:0] bt, input int id);
        bq[ch][tail[ch] % 256] = '{addr: a, len: 8'(len), size: 3'(size), burst: bt, id: IW'(id)};
        tail[ch]++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        bit done = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            done = (head[0] == tail[0]) && (head[1] == tail[1]) && !ch_valid[0] && !ch_valid[1] &&
                   (exp_q.size() == 0) && !busy;
            n++;
        end
        check_eq({tag, "_idle"}, done, 1);
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    int  base;
    bit  seen;
    int  sz;

    initial begin
        tick(3);
        @(negedge clk);
        check_eq("rst_ready", ax_ready, '0);
        check_eq("rst_dvalid", desc_valid, 0);
        check_eq("rst_busy", busy, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        base = desc_cnt;
        enqueue(0, 64'h1030, 7, 3, BURST_INCR, 5);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ax_valid[0] && ax_ready[0];
        end
        check_eq("t1_handshake", seen, 1);
        @(negedge clk);
        check_eq("t1_latency", desc_valid, 1);
        wait_idle("t1");
        check_eq("t1_ndesc", desc_cnt - base, 2);

        base = desc_cnt;
        enqueue(1, 64'h2000, 31, 3, BURST_INCR, 9);
        wait_idle("t2");
        check_eq("t2_ndesc", desc_cnt - base, 4);

        base = desc_cnt;
        enqueue(0, 64'h20_0000, 15, 3, BURST_INCR, 1);
        enqueue(0, 64'h3000, 3, 3, BURST_WRAP, 2);
        enqueue(1, 64'h10_0000, 0, 3, BURST_INCR, 3);
        enqueue(1, 64'hF_FFC0, 15, 3, BURST_INCR, 4);
        wait_idle("t3");
        check_eq("t3_ndesc", desc_cnt - base, 5);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            enqueue(0, 64'h1_0000 + 64'(i) * 64'h40, 3, 3, BURST_INCR, i);
            enqueue(1, 64'h2_0000 + 64'(i) * 64'h40, 3, 3, BURST_INCR, 8 + i);
        end
        wait_idle("t4");
        check_eq("t4_ngrant", gl_n, 8);
        for (int i = 0; i < 4; i++) check_eq("t4_order", grant_log[i], i % 2);

        base = desc_cnt;
        desc_ready = 1'b0;
        enqueue(0, 64'h4000, 47, 3, BURST_INCR, 3);
        tick(3);
        enqueue(1, 64'h5000, 0, 3, BURST_INCR, 4);
        tick(20);
        @(negedge clk);
        check_eq("bp_valid", desc_valid, 1);
        check_eq("bp_busy", busy, 1);
        check_eq("bp_addr", desc.addr, 64'h4000);
        check_eq("bp_no_accept", ax_ready, '0);
        tick(1);
        desc_ready = 1'b1;
        wait_idle("bp");
        check_eq("bp_ndesc", desc_cnt - base, 7);

        stall = 1'b1;
        enqueue(1, 64'h6000, 7, 3, BURST_INCR, 6);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("stall_block", ax_ready, '0);
        end
        tick(1);
        stall = 1'b0;
        wait_idle("stall");

        for (int cyc = 0; cyc < 800; cyc++) begin
            tick(1);
            desc_ready = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < NC; c++) begin
                if (tail[c] - head[c] < 3 && $urandom_range(0, 3) == 0) begin
                    sz = $urandom_range(0, 3);
                    m_c = $urandom_range(0, 9);
                    enqueue(c, 64'($urandom_range(0, 32'h10_0400)) & ~((64'd1 << sz) - 64'd1),
                            $urandom_range(0, 40), sz,
                            (m_c == 0) ? BURST_FIXED : (m_c == 1) ? BURST_WRAP : BURST_INCR,
                            $urandom_range(0, 63));
                end
            end
        end
        tick(1);
        stall = 1'b0;
        desc_ready = 1'b1;
        wait_idle("rand");

        enqueue(0, 64'h8000, 255, 3, BURST_INCR, 7);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        check_eq("rm_busy", seen, 1);
        tick(4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rm_dvalid", desc_valid, 0);
        check_eq("rm_busy_clr", busy, 0);
        tick(1);
        rst = 1'b0;
        tick(4);
        @(negedge clk);
        check_eq("post_rst_dvalid", desc_valid, 0);
        check_eq("post_rst_busy", busy, 0);
        check_eq("exp_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
